// File: rtl/wb_lsu_master_if.sv
// Bundle of the core request/response handshake and the Wishbone data-port signals.
// The master modport is the LSU's view; the slave modport is the core + bus environment.
interface wb_lsu_master_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [2:0]    req_funct3;

    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_misaligned;

    logic [AW-1:0] dwb_adr_o;
    logic [DW-1:0] dwb_dat_o;
    logic [DW-1:0] dwb_dat_i;
    logic          dwb_we_o;
    logic [SW-1:0] dwb_sel_o;
    logic          dwb_cyc_o;
    logic          dwb_stb_o;
    logic          dwb_ack_i;
    logic          dwb_err_i;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3,
        input  dwb_dat_i, dwb_ack_i, dwb_err_i,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_misaligned,
        output dwb_adr_o, dwb_dat_o, dwb_we_o, dwb_sel_o, dwb_cyc_o, dwb_stb_o
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_funct3,
        output dwb_dat_i, dwb_ack_i, dwb_err_i,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_misaligned,
        input  dwb_adr_o, dwb_dat_o, dwb_we_o, dwb_sel_o, dwb_cyc_o, dwb_stb_o
    );
endinterface

// File: rtl/wb_lsu_master.sv
// RV32 load/store unit front end: turns one core request at a time into a single
// classic Wishbone cycle, with alignment/legality checks, lane steering and a timeout.
module wb_lsu_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    wb_lsu_master_if.master   bus
);
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = 4;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_mis_q, rsp_mis_d;
    logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [DW-1:0]     adr_q, adr_d;
    logic [DW-1:0]     dat_q, dat_d;

    logic              illegal_c;
    logic              misaligned_c;
    logic [SW-1:0]     sel_c;
    logic [DW-1:0]     wdat_c;
    logic [DW-1:0]     shifted_c;
    logic [DW-1:0]     ldata_c;
    logic              ack_c;
    logic              err_c;
    logic              tmo_c;

    // Request decode: funct3[1:0] is the access size, funct3[2] the unsigned-load flag.
    always_comb begin
        illegal_c    = (bus.req_funct3 == 3'b011)
                     || (bus.req_funct3[2] && bus.req_funct3[1])
                     || (bus.req_we && bus.req_funct3[2]);
        misaligned_c = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
                     || ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        sel_c  = 4'b1111;
        wdat_c = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                sel_c  = 4'b0001 << bus.req_addr[1:0];
                wdat_c = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                sel_c  = 4'b0011 << bus.req_addr[1:0];
                wdat_c = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                sel_c  = 4'b1111;
                wdat_c = bus.req_wdata;
            end
        endcase
        if (!bus.req_we) begin
            wdat_c = '0;
        end
    end

    // Load data steering and extension from the captured low address bits.
    always_comb begin
        shifted_c = bus.dwb_dat_i >> {lo_q, 3'b000};
        case (f3_q)
            3'b000:  ldata_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'b001:  ldata_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'b100:  ldata_c = {24'd0, shifted_c[7:0]};
            3'b101:  ldata_c = {16'd0, shifted_c[15:0]};
            default: ldata_c = shifted_c;
        endcase
    end

    // Responses are only honoured while our cycle is open.
    assign ack_c = bus.dwb_ack_i & cyc_q;
    assign err_c = bus.dwb_err_i & cyc_q;
    assign tmo_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        lo_d        = lo_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_mis_d   = rsp_mis_q;
        rsp_rdata_d = rsp_rdata_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    req_ready_d = 1'b0;
                    f3_d        = bus.req_funct3;
                    lo_d        = bus.req_addr[1:0];
                    rsp_rdata_d = '0;
                    if (illegal_c || misaligned_c) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = illegal_c;
                        rsp_mis_d   = !illegal_c;
                    end else begin
                        state_d = S_BUS;
                        cnt_d   = '0;
                        cyc_d   = 1'b1;
                        we_d    = bus.req_we;
                        sel_d   = sel_c;
                        adr_d   = {bus.req_addr[31:2], 2'b00};
                        dat_d   = wdat_c;
                    end
                end
            end
            S_BUS: begin
                if (ack_c || err_c || tmo_c) begin
                    state_d     = S_RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_mis_d   = 1'b0;
                    if (err_c || !ack_c) begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        rsp_err_d   = 1'b0;
                        rsp_rdata_d = we_q ? '0 : ldata_c;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_mis_d   = 1'b0;
                rsp_rdata_d = '0;
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
                cyc_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            f3_q        <= '0;
            lo_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_mis_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            lo_q        <= lo_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_mis_q   <= rsp_mis_d;
            rsp_rdata_q <= rsp_rdata_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.rsp_misaligned = rsp_mis_q;
    assign bus.dwb_adr_o      = adr_q;
    assign bus.dwb_dat_o      = dat_q;
    assign bus.dwb_we_o       = we_q;
    assign bus.dwb_sel_o      = sel_q;
    assign bus.dwb_cyc_o      = cyc_q;
    assign bus.dwb_stb_o      = cyc_q;
endmodule

// File: tb/tb_wb_lsu_master.sv
// Scoreboard bench for wb_lsu_master: the driver queues expected responses and bus
// cycles, independent monitors pop and compare as the DUT presents them.
module tb_wb_lsu_master;
    localparam int unsigned TO = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        we;
        int          len;
    } bxn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_lsu_master_if bus ();

    wb_lsu_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rsp_t        rsp_q[$];
    bxn_t        bus_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc_n = 0;
    int          r_mode = 3;     // 0 ack, 1 err, 2 ack+err, 3 silent
    int          r_delay = 0;
    logic [31:0] r_data = '0;
    bit          stray = 1'b0;
    bit          ready_pending = 1'b0;
    bit          in_cyc = 1'b0;
    bit          have_cur = 1'b0;
    int          blen = 0;
    rsp_t        e_rsp;
    bxn_t        cur;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Wishbone responder: answers on the (delay+1)-th cycle of an open cycle.
    initial begin
        int rcnt;
        rcnt = 0;
        bus.dwb_ack_i = 1'b0;
        bus.dwb_err_i = 1'b0;
        bus.dwb_dat_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.dwb_cyc_o) begin
                rcnt++;
                if (r_mode != 3 && rcnt == r_delay + 1) begin
                    bus.dwb_ack_i = (r_mode != 1);
                    bus.dwb_err_i = (r_mode != 0);
                    bus.dwb_dat_i = r_data;
                end else begin
                    bus.dwb_ack_i = 1'b0;
                    bus.dwb_err_i = 1'b0;
                    bus.dwb_dat_i = 32'h5A5A_5A5A;
                end
            end else begin
                rcnt = 0;
                bus.dwb_ack_i = stray;
                bus.dwb_err_i = 1'b0;
                bus.dwb_dat_i = stray ? 32'hFFFF_FFFF : 32'h0;
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (ready_pending) begin
            chk("req_ready_after_rsp", 64'(bus.req_ready), 64'd1);
            ready_pending = 1'b0;
        end
        if (bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 (t=%0t)", $time);
            end else begin
                e_rsp = rsp_q.pop_front();
                chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e_rsp.rdata));
                chk("rsp_err", 64'(bus.rsp_err), 64'(e_rsp.err));
                chk("rsp_misaligned", 64'(bus.rsp_misaligned), 64'(e_rsp.mis));
                chk("rsp_cycle", 64'(cyc_n), 64'(e_rsp.cyc));
            end
            ready_pending = 1'b1;
        end
    end

    // Bus cycle monitor.
    always @(negedge clk) begin
        if (bus.dwb_cyc_o) begin
            if (!in_cyc) begin
                in_cyc = 1'b1;
                blen = 0;
                if (bus_q.size() == 0) begin
                    have_cur = 1'b0;
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_cyc: got cyc=1 adr=0x%0h expected no cycle", bus.dwb_adr_o);
                end else begin
                    have_cur = 1'b1;
                    cur = bus_q.pop_front();
                    chk("dwb_adr", 64'(bus.dwb_adr_o), 64'(cur.adr));
                    chk("dwb_sel", 64'(bus.dwb_sel_o), 64'(cur.sel));
                    chk("dwb_dat", 64'(bus.dwb_dat_o), 64'(cur.dat));
                    chk("dwb_we", 64'(bus.dwb_we_o), 64'(cur.we));
                    chk("dwb_stb", 64'(bus.dwb_stb_o), 64'd1);
                end
            end
            blen++;
        end else if (in_cyc) begin
            in_cyc = 1'b0;
            if (have_cur) chk("cyc_len", 64'(blen), 64'(cur.len));
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input int mode, input int delay,
                         input logic [31:0] data, input logic [3:0] e_sel,
                         input logic [31:0] e_dat, input int e_len,
                         input logic [31:0] e_rdata, input logic e_err, input logic e_mis,
                         input int lat, input bit want_rsp);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_ready_wait: got req_ready=0 expected 1 within 50 cycles");
            return;
        end
        r_mode  = mode;
        r_delay = delay;
        r_data  = data;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_funct3 = f3;
        bus.req_valid  = 1'b1;
        if (e_len > 0) bus_q.push_back('{adr: {addr[31:2], 2'b00}, sel: e_sel, dat: e_dat, we: we, len: e_len});
        if (want_rsp) rsp_q.push_back('{rdata: e_rdata, err: e_err, mis: e_mis, cyc: cyc_n + 1 + lat});
        @(posedge clk);
        #1;
        // Garbage on the request lines while busy must not leak into the cycle.
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'hFFFF_FFFF;
        bus.req_wdata  = 32'h1357_9BDF;
        bus.req_we     = ~we;
        bus.req_funct3 = 3'b010;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_funct3 = '0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_misaligned,
                             bus.dwb_cyc_o, bus.dwb_stb_o, bus.dwb_we_o, bus.dwb_sel_o}), 64'h400);
        chk("rst_adr", 64'(bus.dwb_adr_o), 64'd0);
        chk("rst_dat", 64'(bus.dwb_dat_o), 64'd0);
        chk("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
        rst = 1'b0;

        // Stray ack/err while idle must be ignored (monitors flag any reaction).
        @(negedge clk);
        stray = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b0;
        chk("stray_ack_idle", 64'({bus.rsp_valid, bus.dwb_cyc_o, bus.req_ready}), 64'b001);

        //     we    addr           wdata          f3      md dl data           sel      dat_o          len rdata          e  m  lat rsp
        issue(1'b0, 32'h0000_1003, 32'h0,         3'b000, 0, 1, 32'h80FF_0000, 4'b1000, 32'h0,         2, 32'hFFFF_FF80, 0, 0, 2, 1);
        issue(1'b1, 32'h0000_2002, 32'h0000_BEEF, 3'b001, 0, 0, 32'h0,         4'b1100, 32'hBEEF_BEEF, 1, 32'h0,         0, 0, 1, 1);
        issue(1'b0, 32'h0000_3001, 32'h0,         3'b010, 3, 0, 32'h0,         4'b0000, 32'h0,         0, 32'h0,         0, 1, 0, 1);
        issue(1'b0, 32'h0000_4000, 32'h0,         3'b101, 2, 0, 32'h1234_ABCD, 4'b0011, 32'h0,         1, 32'h0,         1, 0, 1, 1);
        issue(1'b0, 32'h0000_5000, 32'h0,         3'b010, 3, 0, 32'h0,         4'b1111, 32'h0,         4, 32'h0,         1, 0, 4, 1);
        issue(1'b0, 32'h0000_6001, 32'h0,         3'b100, 0, 2, 32'h0000_9A00, 4'b0010, 32'h0,         3, 32'h0000_009A, 0, 0, 3, 1);
        issue(1'b0, 32'h0000_7002, 32'h0,         3'b001, 0, 0, 32'h8001_0000, 4'b1100, 32'h0,         1, 32'hFFFF_8001, 0, 0, 1, 1);
        issue(1'b0, 32'h0000_7002, 32'h0,         3'b101, 0, 0, 32'h8001_0000, 4'b1100, 32'h0,         1, 32'h0000_8001, 0, 0, 1, 1);
        issue(1'b0, 32'h0000_8000, 32'h0,         3'b010, 0, 1, 32'hDEAD_BEEF, 4'b1111, 32'h0,         2, 32'hDEAD_BEEF, 0, 0, 2, 1);
        issue(1'b1, 32'h0000_9001, 32'h1234_56A5, 3'b000, 0, 0, 32'h0,         4'b0010, 32'hA5A5_A5A5, 1, 32'h0,         0, 0, 1, 1);
        issue(1'b1, 32'h0000_A000, 32'hCAFE_F00D, 3'b010, 0, 1, 32'h0,         4'b1111, 32'hCAFE_F00D, 2, 32'h0,         0, 0, 2, 1);
        issue(1'b0, 32'h0000_0000, 32'h0,         3'b011, 3, 0, 32'h0,         4'b0000, 32'h0,         0, 32'h0,         1, 0, 0, 1);
        issue(1'b1, 32'h0000_0000, 32'h0,         3'b100, 3, 0, 32'h0,         4'b0000, 32'h0,         0, 32'h0,         1, 0, 0, 1);
        issue(1'b0, 32'h0000_0003, 32'h0,         3'b111, 3, 0, 32'h0,         4'b0000, 32'h0,         0, 32'h0,         1, 0, 0, 1);
        issue(1'b0, 32'h0000_0001, 32'h0,         3'b001, 3, 0, 32'h0,         4'b0000, 32'h0,         0, 32'h0,         0, 1, 0, 1);
        issue(1'b0, 32'h0000_B000, 32'h0,         3'b000, 1, 0, 32'h0000_00AA, 4'b0001, 32'h0,         1, 32'h0,         1, 0, 1, 1);
        issue(1'b0, 32'h0000_E000, 32'h0,         3'b000, 0, 0, 32'hFFFF_FF7F, 4'b0001, 32'h0,         1, 32'h0000_007F, 0, 0, 1, 1);

        // Reset two cycles into a silent SW: cycle seen for exactly two cycles, no response.
        issue(1'b1, 32'h0000_C000, 32'h0BAD_F00D, 3'b010, 3, 0, 32'h0,         4'b1111, 32'h0BAD_F00D, 2, 32'h0,         0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_drops_cyc_stb", 64'({bus.dwb_cyc_o, bus.dwb_stb_o}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_ctrl", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_misaligned,
                                bus.dwb_cyc_o, bus.dwb_stb_o, bus.dwb_we_o, bus.dwb_sel_o}), 64'h400);
        chk("midrst_adr", 64'(bus.dwb_adr_o), 64'd0);
        chk("midrst_dat", 64'(bus.dwb_dat_o), 64'd0);
        rst = 1'b0;

        issue(1'b0, 32'h0000_D004, 32'h0,         3'b010, 0, 0, 32'h1122_3344, 4'b1111, 32'h0,         1, 32'h1122_3344, 0, 0, 1, 1);

        for (int i = 0; i < 40 && (rsp_q.size() != 0 || bus_q.size() != 0 || in_cyc); i++) @(negedge clk);
        repeat (2) @(negedge clk);
        while (rsp_q.size() != 0) begin
            e_rsp = rsp_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_rsp: got no rsp_valid expected one in cycle %0d", e_rsp.cyc);
        end
        while (bus_q.size() != 0) begin
            cur = bus_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_cyc: got no cycle expected adr=0x%0h", cur.adr);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
